// File: rtl/nav_pkg.sv
// rtl/nav_pkg.sv - shared parser state, ASCII codes and milli-unit scaling
package nav_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_KEY_OPEN,
        ST_KEY,
        ST_KEY_CLOSE,
        ST_COLON,
        ST_VALUE,
        ST_SKIP,
        ST_OBJ_END,
        ST_DISCARD
    } rx_state_t;

    localparam logic [7:0] CH_LBRACE = 8'h7B;
    localparam logic [7:0] CH_RBRACE = 8'h7D;
    localparam logic [7:0] CH_QUOTE  = 8'h22;
    localparam logic [7:0] CH_COLON  = 8'h3A;
    localparam logic [7:0] CH_COMMA  = 8'h2C;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_MINUS  = 8'h2D;
    localparam logic [7:0] CH_LF     = 8'h0A;
    localparam logic [7:0] CH_CR     = 8'h0D;
    localparam logic [7:0] CH_SPACE  = 8'h20;
    localparam logic [7:0] CH_T      = 8'h54;
    localparam logic [7:0] CH_L      = 8'h4C;
    localparam logic [7:0] CH_R      = 8'h52;

    localparam int MILLI_SCALE = 1000;

    localparam logic [1:0] KEY_T = 2'd0;
    localparam logic [1:0] KEY_L = 2'd1;
    localparam logic [1:0] KEY_R = 2'd2;

    // Multiplier that brings an accumulator with nfrac fraction digits to milli-units.
    function automatic logic [9:0] frac_scale(input logic [1:0] nfrac);
        case (nfrac)
            2'd0:    frac_scale = 10'(MILLI_SCALE);
            2'd1:    frac_scale = 10'd100;
            2'd2:    frac_scale = 10'd10;
            default: frac_scale = 10'd1;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 (optionally parity) UART receiver, one valid pulse per byte
module uart_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int BITS_N       = 8,
    parameter int PARITY_TYPE  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_rx,
    output logic [BITS_N-1:0] o_data,
    output logic              o_valid,
    output logic              o_err
);
    localparam int NBITS = (PARITY_TYPE != 0) ? BITS_N + 1 : BITS_N;
    localparam int CW    = $clog2(CLKS_PER_BIT + 1);
    localparam int BW    = $clog2(NBITS + 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_phase_t;

    rx_phase_t         r_phase;
    logic [2:0]        r_sync;
    logic [CW-1:0]     r_cnt;
    logic [BW-1:0]     r_bit;
    logic [NBITS-1:0]  r_shift;
    logic [BITS_N-1:0] r_data;
    logic              r_valid;
    logic              r_err;
    logic              w_rx;
    logic              w_fall;
    logic              w_par_bad;

    assign w_rx   = r_sync[1];
    assign w_fall = r_sync[2] & ~r_sync[1];

    always_comb begin
        w_par_bad = 1'b0;
        if (PARITY_TYPE == 1)
            w_par_bad = ~(^r_shift);
        else if (PARITY_TYPE == 2)
            w_par_bad = ^r_shift;
    end

    // A new start bit needs a falling edge, so a low stop bit cannot retrigger reception.
    always_ff @(posedge clk) begin
        r_sync  <= {r_sync[1:0], i_rx};
        r_valid <= 1'b0;
        if (rst) begin
            r_sync  <= 3'b111;
            r_phase <= RX_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            case (r_phase)
                RX_IDLE: begin
                    r_cnt <= '0;
                    if (w_fall)
                        r_phase <= RX_START;
                end
                RX_START: begin
                    if (r_cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_phase <= w_rx ? RX_IDLE : RX_DATA;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx, r_shift[NBITS-1:1]};
                        if (r_bit == BW'(NBITS - 1))
                            r_phase <= RX_STOP;
                        else
                            r_bit <= r_bit + BW'(1);
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    if (r_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                        r_data  <= r_shift[BITS_N-1:0];
                        r_err   <= ~w_rx | w_par_bad;
                        r_phase <= RX_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            endcase
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_err   = r_err;

endmodule

// File: rtl/json_feedback_rx.sv
// rtl/json_feedback_rx.sv - JSON rover feedback line parser; JSON_RX_ERR_COUNT_EN adds err_count
module json_feedback_rx
    import nav_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int MAX_LINE_LEN = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_in,
    output logic        fb_valid,
    output logic [15:0] fb_type,
    output logic [15:0] fb_left,
    output logic [15:0] fb_right,
    output logic [2:0]  fb_present,
    output logic        parse_err
`ifdef JSON_RX_ERR_COUNT_EN
    ,
    output logic [15:0] err_count
`endif
);
    localparam int CNT_W = $clog2(MAX_LINE_LEN + 2);
    localparam logic [31:0] ACC_CAP = 32'd1_000_000;

    logic [7:0]       w_byte;
    logic             w_byte_valid;
    logic             w_stop_err;

    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_first;
    logic [1:0]       r_key;
    logic             r_neg, r_nint, r_dot, r_vdone;
    logic [1:0]       r_nfrac;
    logic [31:0]      r_acc;
    logic [15:0]      r_stg_t, r_stg_l, r_stg_r;
    logic [2:0]       r_stg_p;
    logic             r_valid, r_perr;
    logic [15:0]      r_type, r_left, r_right;
    logic [2:0]       r_present;

    logic             w_ws, w_is_digit, w_in_frame, w_gen_err, w_tok_err;
    logic [CNT_W-1:0] w_cnt_next;
    logic [31:0]      w_acc_mul, w_acc_sat, w_scaled;
    logic [15:0]      w_t_val, w_lr_val;

    uart_rx #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .BITS_N       (8),
        .PARITY_TYPE  (0)
    ) u_uart_rx (
        .clk     (clk),
        .rst     (rst),
        .i_rx    (uart_in),
        .o_data  (w_byte),
        .o_valid (w_byte_valid),
        .o_err   (w_stop_err)
    );

    assign w_ws       = (w_byte == CH_SPACE) || (w_byte == CH_CR);
    assign w_is_digit = (w_byte >= 8'h30) && (w_byte <= 8'h39);
    assign w_in_frame = (r_state != ST_IDLE) && (r_state != ST_DISCARD);
    assign w_cnt_next = r_cnt + CNT_W'(1);
    assign w_acc_mul  = r_acc * 32'd10 + {28'd0, w_byte[3:0]};
    assign w_acc_sat  = (w_acc_mul > ACC_CAP) ? ACC_CAP : w_acc_mul;
    assign w_scaled   = r_acc * {22'd0, frac_scale(r_nfrac)};
    assign w_t_val    = (r_acc > 32'd65535) ? 16'hFFFF : r_acc[15:0];

    always_comb begin
        if (r_neg)
            w_lr_val = (w_scaled > 32'd32768) ? 16'h8000 : 16'(32'd0 - w_scaled);
        else
            w_lr_val = (w_scaled > 32'd32767) ? 16'h7FFF : w_scaled[15:0];
    end

    // Errors that apply in every in-frame state, then per-state token checks.
    assign w_gen_err = w_in_frame && (w_stop_err || (w_cnt_next > CNT_W'(MAX_LINE_LEN)) ||
                       (w_byte == CH_LBRACE) || ((w_byte == CH_LF) && (r_state != ST_OBJ_END)));

    always_comb begin
        w_tok_err = 1'b0;
        case (r_state)
            ST_KEY_OPEN:  w_tok_err = !((w_byte == CH_QUOTE) || w_ws || ((w_byte == CH_RBRACE) && r_first));
            ST_KEY_CLOSE: w_tok_err = (w_byte == CH_QUOTE) && r_stg_p[r_key];
            ST_COLON:     w_tok_err = !((w_byte == CH_COLON) || w_ws);
            ST_VALUE: begin
                if (w_ws)
                    w_tok_err = 1'b0;
                else if (w_byte == CH_MINUS)
                    w_tok_err = r_nint || r_neg || (r_key == KEY_T);
                else if (w_is_digit)
                    w_tok_err = r_vdone;
                else if (w_byte == CH_DOT)
                    w_tok_err = (r_key == KEY_T) || r_dot || !r_nint || r_vdone;
                else if ((w_byte == CH_COMMA) || (w_byte == CH_RBRACE))
                    w_tok_err = !r_nint;
                else
                    w_tok_err = 1'b1;
            end
            ST_OBJ_END:   w_tok_err = !((w_byte == CH_LF) || w_ws);
            default:      w_tok_err = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        r_valid <= 1'b0;
        r_perr  <= 1'b0;
        if (rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_first   <= 1'b0;
            r_key     <= KEY_T;
            r_neg     <= 1'b0;
            r_nint    <= 1'b0;
            r_dot     <= 1'b0;
            r_vdone   <= 1'b0;
            r_nfrac   <= 2'd0;
            r_acc     <= '0;
            r_stg_t   <= '0;
            r_stg_l   <= '0;
            r_stg_r   <= '0;
            r_stg_p   <= '0;
            r_type    <= '0;
            r_left    <= '0;
            r_right   <= '0;
            r_present <= '0;
        end else if (w_byte_valid) begin
            if (w_in_frame)
                r_cnt <= w_cnt_next;
            if (w_gen_err || w_tok_err) begin
                r_perr  <= 1'b1;
                r_state <= (w_byte == CH_LF) ? ST_IDLE : ST_DISCARD;
            end else begin
                case (r_state)
                    ST_IDLE: if ((w_byte == CH_LBRACE) && !w_stop_err) begin
                        r_state <= ST_KEY_OPEN;
                        r_cnt   <= CNT_W'(1);
                        r_first <= 1'b1;
                        r_stg_p <= '0;
                    end
                    ST_KEY_OPEN: begin
                        if (w_byte == CH_QUOTE)
                            r_state <= ST_KEY;
                        else if (w_byte == CH_RBRACE)
                            r_state <= ST_OBJ_END;
                    end
                    ST_KEY: begin
                        r_state <= ST_KEY_CLOSE;
                        if (w_byte == CH_T)
                            r_key <= KEY_T;
                        else if (w_byte == CH_L)
                            r_key <= KEY_L;
                        else if (w_byte == CH_R)
                            r_key <= KEY_R;
                        else
                            r_state <= ST_SKIP;
                    end
                    ST_KEY_CLOSE: r_state <= (w_byte == CH_QUOTE) ? ST_COLON : ST_SKIP;
                    ST_COLON: if (w_byte == CH_COLON) begin
                        r_state <= ST_VALUE;
                        r_acc   <= '0;
                        r_neg   <= 1'b0;
                        r_nint  <= 1'b0;
                        r_dot   <= 1'b0;
                        r_nfrac <= 2'd0;
                        r_vdone <= 1'b0;
                    end
                    ST_VALUE: begin
                        if (w_ws) begin
                            if (r_neg || r_nint)
                                r_vdone <= 1'b1;
                        end else if (w_byte == CH_MINUS) begin
                            r_neg <= 1'b1;
                        end else if (w_is_digit) begin
                            if (!r_dot) begin
                                r_acc  <= w_acc_sat;
                                r_nint <= 1'b1;
                            end else if (r_nfrac != 2'd3) begin
                                r_acc   <= w_acc_sat;
                                r_nfrac <= r_nfrac + 2'd1;
                            end
                        end else if (w_byte == CH_DOT) begin
                            r_dot <= 1'b1;
                        end else begin
                            case (r_key)
                                KEY_T:   r_stg_t <= w_t_val;
                                KEY_L:   r_stg_l <= w_lr_val;
                                default: r_stg_r <= w_lr_val;
                            endcase
                            r_stg_p[r_key] <= 1'b1;
                            r_first <= 1'b0;
                            r_state <= (w_byte == CH_COMMA) ? ST_KEY_OPEN : ST_OBJ_END;
                        end
                    end
                    ST_SKIP: begin
                        if (w_byte == CH_COMMA) begin
                            r_first <= 1'b0;
                            r_state <= ST_KEY_OPEN;
                        end else if (w_byte == CH_RBRACE) begin
                            r_state <= ST_OBJ_END;
                        end
                    end
                    ST_OBJ_END: if (w_byte == CH_LF) begin
                        r_valid   <= 1'b1;
                        r_present <= r_stg_p;
                        if (r_stg_p[0]) r_type  <= r_stg_t;
                        if (r_stg_p[1]) r_left  <= r_stg_l;
                        if (r_stg_p[2]) r_right <= r_stg_r;
                        r_state <= ST_IDLE;
                    end
                    default: if (w_byte == CH_LF) r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign fb_valid   = r_valid;
    assign parse_err  = r_perr;
    assign fb_type    = r_type;
    assign fb_left    = r_left;
    assign fb_right   = r_right;
    assign fb_present = r_present;

`ifdef JSON_RX_ERR_COUNT_EN
    logic [15:0] r_err_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_err_cnt <= '0;
        else if (r_perr && (r_err_cnt != 16'hFFFF))
            r_err_cnt <= r_err_cnt + 16'd1;
    end

    assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_json_feedback_rx.sv
// tb/tb_json_feedback_rx.sv - directed serial frames against json_feedback_rx
module tb_json_feedback_rx;
    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_in = 1'b1;
    logic        fb_valid;
    logic [15:0] fb_type, fb_left, fb_right;
    logic [2:0]  fb_present;
    logic        parse_err;
`ifdef JSON_RX_ERR_COUNT_EN
    logic [15:0] err_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int n_err    = 0;
    logic both_seen = 1'b0;

    json_feedback_rx #(
        .CLKS_PER_BIT (CPB),
        .MAX_LINE_LEN (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_in    (uart_in),
        .fb_valid   (fb_valid),
        .fb_type    (fb_type),
        .fb_left    (fb_left),
        .fb_right   (fb_right),
        .fb_present (fb_present),
        .parse_err  (parse_err)
`ifdef JSON_RX_ERR_COUNT_EN
        ,
        .err_count  (err_count)
`endif
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fb_valid) n_valid++;
        if (parse_err) n_err++;
        if (fb_valid && parse_err) both_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [15:0] t, input logic [15:0] l,
                              input logic [15:0] r, input logic [2:0] p);
        check({tag, "_type"}, fb_type, t);
        check({tag, "_left"}, fb_left, l);
        check({tag, "_right"}, fb_right, r);
        check({tag, "_present"}, 16'(fb_present), 16'(p));
    endtask

    task automatic check_counts(input string tag, input int nv, input int ne);
        check({tag, "_nvalid"}, 16'(n_valid), 16'(nv));
        check({tag, "_nerr"}, 16'(n_err), 16'(ne));
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
        @(negedge clk);
        uart_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_in = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_in = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++)
            send_byte(s[i]);
        repeat (4 * CPB) @(negedge clk);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_valid", 16'(fb_valid), 16'd0);
        check("rst_perr", 16'(parse_err), 16'd0);
        check_outs("rst", 16'd0, 16'd0, 16'd0, 3'b000);

        send_str("\n");
        check_counts("idle_lf", 0, 0);

        send_str("{\"T\":1,\"L\":0.05,\"R\":-0.05}\n");
        check_counts("f1", 1, 0);
        check_outs("f1", 16'd1, 16'd50, 16'(-50), 3'b111);

        send_str("{\"T\":1001,\"X\":\"abc\",\"L\":1.5}\n");
        check_counts("f2", 2, 0);
        check_outs("f2", 16'd1001, 16'd1500, 16'(-50), 3'b011);

        send_str("{\"T\":2,\"L\":0.0.1}\n");
        check_counts("dbl_dot", 2, 1);
        check_outs("dbl_dot", 16'd1001, 16'd1500, 16'(-50), 3'b011);

        send_str("{\"R\":3}\n");
        check_counts("f3", 3, 1);
        check_outs("f3", 16'd1001, 16'd1500, 16'd3000, 3'b100);

        send_str("{ \"T\" : 5 , \"L\":-0.5 }\r\n");
        check_counts("ws", 4, 1);
        check_outs("ws", 16'd5, 16'(-500), 16'd3000, 3'b011);

        send_str("{}\n");
        check_counts("empty", 5, 1);
        check_outs("empty", 16'd5, 16'(-500), 16'd3000, 3'b000);

        send_str("{\"T\":70000,\"L\":-40}\n");
        check_counts("sat", 6, 1);
        check_outs("sat", 16'hFFFF, 16'h8000, 16'd3000, 3'b011);

        send_str("{\"T\":1,\"T\":2}\n");
        check_counts("dup", 6, 2);
        send_str("{\"T\":-1}\n");
        check_counts("t_neg", 6, 3);
        send_str("{\"L\":{}\n");
        check_counts("brace", 6, 4);

        send_str("{\"T\":");
        send_byte(8'h37, 1'b0);
        send_str("\n");
        check_counts("stop_low", 6, 5);
        check_outs("stop_low", 16'hFFFF, 16'h8000, 16'd3000, 3'b011);

        send_str("{\"L\":99.9999}\n");
        check_counts("f4", 7, 5);
        check_outs("f4", 16'hFFFF, 16'h7FFF, 16'd3000, 3'b010);

        send_byte(8'h7B);
        send_byte(8'h22);
        for (int i = 0; i < 62; i++) send_byte(8'h61);
        repeat (4 * CPB) @(negedge clk);
        check_counts("len64", 7, 5);
        send_byte(8'h61);
        repeat (4 * CPB) @(negedge clk);
        check_counts("len65", 7, 6);
        for (int i = 0; i < 5; i++) send_byte(8'h61);
        send_str("\n");
        check_counts("len70", 7, 6);

        send_str("{\"T\":");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_outs("mid_rst", 16'd0, 16'd0, 16'd0, 3'b000);
        send_str("{\"R\":-2}\n");
        check_counts("f5", 8, 6);
        check_outs("f5", 16'd0, 16'd0, 16'(-2000), 3'b100);

        send_str("{\"T\":3\n");
        send_str("{\"T\":4}\n");
        check_counts("lf_early", 9, 7);
        check_outs("lf_early", 16'd4, 16'd0, 16'(-2000), 3'b001);

        check("exclusive", 16'(both_seen), 16'd0);
`ifdef JSON_RX_ERR_COUNT_EN
        check("err_count", err_count, 16'd7);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/json_feedback_rx.md
JSON_FEEDBACK_RX -- requirements
Module: json_feedback_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, UART bit period in clk cycles (115200 baud at 50 MHz).
REQ-002 Parameter MAX_LINE_LEN, default 64, maximum bytes per line including '\n'.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 uart_in  input  1  serial line from the rover; 8N1, idle high.
REQ-006 fb_valid  output  1  one-cycle pulse when a complete frame has parsed.
REQ-007 fb_type  output  16  unsigned value of key "T".
REQ-008 fb_left  output  16  signed value of key "L", in milli-units.
REQ-009 fb_right  output  16  signed value of key "R", in milli-units.
REQ-010 fb_present  output  3  {R,L,T} flags: key was present in the last valid frame.
REQ-011 parse_err  output  1  one-cycle pulse when a line is rejected.

Function
REQ-012 Frame format: '{' key ':' value { ',' key ':' value } '}' '\n'; each key is a double-quoted string; ' ' and '\r' are ignored outside keys and numbers.
REQ-013 FSM states: IDLE (wait '{'), KEY_OPEN, KEY, KEY_CLOSE, COLON, VALUE, SKIP, OBJ_END (wait '\n'), DISCARD (wait '\n').
REQ-014 IDLE drops every byte other than '{'; a '\n' in IDLE produces no pulse.
REQ-015 Recognised keys: exactly "T", "L", "R"; a key of any other name or length enters SKIP, which drops bytes until ',' or '}'.
REQ-016 Value grammar: optional '-', 1+ integer digits, optional '.', 0+ fraction digits.
REQ-017 Accumulation per digit: acc = acc*10 + d; digits past the third fraction digit are ignored; the result is scaled by 10^(3-nfrac).
REQ-018 Value examples: "0.05" -> 50; "-0.5" -> -500; "1" -> 1000.
REQ-019 "T" is integer only; a '.' or '-' in a "T" value is an error; T saturates at 65535.
REQ-020 L and R saturate to +32767 / -32768; saturation is not an error.
REQ-021 Errors: unexpected character in any state except IDLE/SKIP; '\n' before '}'; byte count over MAX_LINE_LEN; duplicate key; UART stop bit low.
REQ-022 On error: parse_err pulses once; FSM enters DISCARD, or IDLE directly if the offending byte was '\n'; outputs are unchanged.
REQ-023 On '\n' in OBJ_END: fields are staged, so fb_type, fb_left, fb_right and fb_present update only for present keys.
REQ-024 Output timing: fb_type, fb_left, fb_right and fb_present update in the same cycle fb_valid pulses, one cycle after the '\n' byte is accepted from the receiver.
REQ-025 Absent keys keep their previous output value; the matching fb_present bit is 0.
REQ-026 Empty object "{}\n" is valid: fb_valid pulses and fb_present=000.
REQ-027 A '{' inside a frame is an error; the FSM does not resynchronise until the next '\n'.
REQ-028 fb_valid and parse_err never assert in the same cycle.

Reset
REQ-029 On rst: FSM=IDLE; accumulators, byte count and staging are cleared.
REQ-030 On rst: fb_valid=0, parse_err=0, fb_type=0, fb_left=0, fb_right=0, fb_present=000.
REQ-031 rst mid-frame discards the partial frame with no pulse; parsing restarts at the next '{'.

Configuration
REQ-032 Macro JSON_RX_ERR_COUNT_EN.
REQ-033 With JSON_RX_ERR_COUNT_EN defined: an extra output err_count (16 bits) increments on each parse_err pulse, saturates at 65535 and resets to 0.
REQ-034 Without JSON_RX_ERR_COUNT_EN: the err_count port and its logic are absent; all other behaviour is identical.

Structure
REQ-035 Shared package nav_pkg holds: the FSM state enum, ASCII constants ('{', '}', '"', ':', ',', '.', '-', '\n', '\r', ' '), and the milli-unit scale constant 1000.
REQ-036 Sub-module uart_rx (parameters CLKS_PER_BIT, BITS_N=8, PARITY_TYPE=0) deserialises uart_in into data plus a valid pulse; json_feedback_rx contains only the parser.

Verification
REQ-037 Send {"T":1,"L":0.05,"R":-0.05}\n -> one fb_valid pulse; fb_type=1, fb_left=50, fb_right=-50, fb_present=111.
REQ-038 Send {"T":1001,"X":"abc","L":1.5}\n -> fb_type=1001, fb_left=1500, fb_right unchanged, fb_present=011.
REQ-039 Send {"T":2,"L":0.0.1}\n -> one parse_err pulse; no fb_valid; outputs unchanged; the following valid frame parses normally.
REQ-040 Send {"L":99.9999}\n -> fb_left=32767 (saturated), fb_present=010; then 70 bytes with no '\n' -> parse_err once at byte 65.
REQ-041 Assert rst after the '{"T":' bytes, then send {"R":-2}\n -> all outputs zero after reset; then fb_right=-2000, fb_present=100.
REQ-042 With JSON_RX_ERR_COUNT_EN defined: three malformed lines then one good frame -> err_count=3; fb_valid pulses exactly once.
